// File: rtl/lstm_dense_decider_if.sv
// Handshake and parameter-write bundle for lstm_dense_decider.
// The slave modport is the decider side; the master modport is the driving side.
interface lstm_dense_decider_if #(
    parameter int DATA_WIDTH  = 14,
    parameter int NUM_HIDDEN  = 16,
    parameter int NUM_CLASSES = 16
);
    localparam int AW = $clog2(NUM_CLASSES * (NUM_HIDDEN + 1));
    localparam int SW = $clog2(NUM_CLASSES);

    logic                  h_valid;
    logic                  h_ready;
    logic [DATA_WIDTH-1:0] h_data;
    logic                  w_we;
    logic [AW-1:0]         w_addr;
    logic [DATA_WIDTH-1:0] w_data;
    logic                  sym_valid;
    logic                  sym_ready;
    logic [SW-1:0]         sym;
    logic [DATA_WIDTH-1:0] score;

    modport master (
        output h_valid, h_data, w_we, w_addr, w_data, sym_ready,
        input  h_ready, sym_valid, sym, score
    );

    modport slave (
        input  h_valid, h_data, w_we, w_addr, w_data, sym_ready,
        output h_ready, sym_valid, sym, score
    );
endinterface

// File: rtl/lstm_dense_decider.sv
// Dense layer + argmax over one frame of LSTM hidden values, single serialized MAC.
// Optional DENSE_SCORE_OUT_EN: emit the rounded, saturated winning logit on score.
module lstm_dense_decider #(
    parameter int DATA_WIDTH  = 14,
    parameter int FRAC_BITS   = 10,
    parameter int NUM_HIDDEN  = 16,
    parameter int NUM_CLASSES = 16,
    parameter int ACC_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    lstm_dense_decider_if.slave  bus
);
    localparam int NPARAM = NUM_CLASSES * (NUM_HIDDEN + 1);
    localparam int AW     = $clog2(NPARAM);
    localparam int KW     = $clog2(NUM_HIDDEN);
    localparam int JW     = $clog2(NUM_CLASSES);

    typedef enum logic [1:0] {IDLE, MAC, ARGMAX, DONE} state_t;

    state_t                        state_q, state_d;
    logic [KW-1:0]                 k_q;
    logic [JW-1:0]                 j_q;
    logic signed [DATA_WIDTH-1:0]  h_q;
    logic signed [DATA_WIDTH-1:0]  param_mem [NPARAM];
    logic signed [ACC_WIDTH-1:0]   acc_q [NUM_CLASSES];
    logic signed [ACC_WIDTH-1:0]   best_q, best_d;
    logic [JW-1:0]                 best_idx_q, best_idx_d, sym_q;
    logic [DATA_WIDTH-1:0]         score_q, score_d;

    logic                          last_j, last_k, h_acc, p_wr;
    logic [AW-1:0]                 w_idx, b_idx;
    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH-1:0]   mac_base, acc_d, cand;

    assign last_j = (j_q == JW'(NUM_CLASSES - 1));
    assign last_k = (k_q == KW'(NUM_HIDDEN - 1));
    assign h_acc  = (state_q == IDLE) && bus.h_valid;
    // Parameters only change between frames so a frame never sees mixed weights.
    assign p_wr   = (state_q == IDLE) && (k_q == '0) && bus.w_we &&
                    (32'(bus.w_addr) < 32'(NPARAM));

    assign bus.h_ready   = (state_q == IDLE);
    assign bus.sym_valid = (state_q == DONE);
    assign bus.sym       = sym_q;
    assign bus.score     = score_q;

    assign w_idx    = AW'(int'(j_q) * (NUM_HIDDEN + 1) + int'(k_q));
    assign b_idx    = AW'(int'(j_q) * (NUM_HIDDEN + 1) + NUM_HIDDEN);
    assign prod     = param_mem[w_idx] * h_q;
    // First element of a frame seeds the accumulator with the aligned bias.
    assign mac_base = (k_q == '0) ? (ACC_WIDTH'(param_mem[b_idx]) <<< FRAC_BITS) : acc_q[j_q];
    assign acc_d    = mac_base + ACC_WIDTH'(prod);
    assign cand     = acc_q[j_q];

    always_comb begin
        best_d     = best_q;
        best_idx_d = best_idx_q;
        if ((j_q == '0) || (cand > best_q)) begin
            best_d     = cand;
            best_idx_d = j_q;
        end
    end

`ifdef DENSE_SCORE_OUT_EN
    localparam logic signed [ACC_WIDTH:0] HALF = (ACC_WIDTH+1)'(1) <<< (FRAC_BITS - 1);
    localparam logic signed [ACC_WIDTH:0] SMAX = (ACC_WIDTH+1)'((1 <<< (DATA_WIDTH - 1)) - 1);
    localparam logic signed [ACC_WIDTH:0] SMIN = -SMAX - (ACC_WIDTH+1)'(1);
    logic signed [ACC_WIDTH:0] rnd;

    always_comb begin
        rnd = ((ACC_WIDTH+1)'(best_d) + HALF) >>> FRAC_BITS;
        if (rnd > SMAX)      score_d = SMAX[DATA_WIDTH-1:0];
        else if (rnd < SMIN) score_d = SMIN[DATA_WIDTH-1:0];
        else                 score_d = rnd[DATA_WIDTH-1:0];
    end
`else
    assign score_d = '0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (h_acc) state_d = MAC;
            MAC:     if (last_j) state_d = last_k ? ARGMAX : IDLE;
            ARGMAX:  if (last_j) state_d = DONE;
            DONE:    if (bus.sym_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (p_wr) param_mem[bus.w_addr] <= bus.w_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k_q        <= '0;
            j_q        <= '0;
            h_q        <= '0;
            best_q     <= '0;
            best_idx_q <= '0;
            sym_q      <= '0;
            score_q    <= '0;
            for (int i = 0; i < NUM_CLASSES; i++) acc_q[i] <= '0;
        end else begin
            case (state_q)
                IDLE: if (h_acc) begin
                    h_q <= bus.h_data;
                    j_q <= '0;
                end
                MAC: begin
                    acc_q[j_q] <= acc_d;
                    if (last_j) begin
                        j_q <= '0;
                        if (!last_k) k_q <= k_q + KW'(1);
                    end else begin
                        j_q <= j_q + JW'(1);
                    end
                end
                ARGMAX: begin
                    best_q     <= best_d;
                    best_idx_q <= best_idx_d;
                    if (last_j) begin
                        j_q     <= '0;
                        sym_q   <= best_idx_d;
                        score_q <= score_d;
                    end else begin
                        j_q <= j_q + JW'(1);
                    end
                end
                DONE: if (bus.sym_ready) k_q <= '0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_lstm_dense_decider.sv
// Scoreboard bench for lstm_dense_decider: directed frames plus random frames
// checked against a plain-arithmetic dense/argmax model.
module tb_lstm_dense_decider;
    localparam int DW = 14;
    localparam int FB = 10;
    localparam int NH = 16;
    localparam int NC = 16;
    localparam int NP = NC * (NH + 1);
    localparam int AW = $clog2(NP);

    logic clk = 1'b0;
    logic rst = 1'b0;

    lstm_dense_decider_if #(.DATA_WIDTH(DW), .NUM_HIDDEN(NH), .NUM_CLASSES(NC)) bus ();

    lstm_dense_decider #(
        .DATA_WIDTH(DW), .FRAC_BITS(FB), .NUM_HIDDEN(NH), .NUM_CLASSES(NC), .ACC_WIDTH(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial forever #5 clk = ~clk;

    typedef struct { int sym; int score; int acc_cyc; int min_len; } exp_t;
    exp_t expq[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int sent_cnt = 0;
    int hold_set = 0;
    int last_acc = 0;
    int pm [NP];
    int hv [NH];

    function automatic int s14(input int v);
        logic [DW-1:0] t;
        t = v[DW-1:0];
        return int'($signed(t));
    endfunction

    // Reference: logit_j = bias_j * 2^FB + sum_k W[j][k]*h[k]; first strict max wins.
    function automatic exp_t model(input int acyc, input int mlen);
        exp_t   e;
        longint lg, best, r;
        best  = 0;
        e.sym = 0;
        for (int j = 0; j < NC; j++) begin
            lg = longint'(pm[j*(NH+1)+NH]) * (longint'(1) << FB);
            for (int k = 0; k < NH; k++) lg += longint'(pm[j*(NH+1)+k]) * longint'(hv[k]);
            lg = longint'($signed(lg[31:0]));
            if (j == 0 || lg > best) begin
                best  = lg;
                e.sym = j;
            end
        end
`ifdef DENSE_SCORE_OUT_EN
        r = (best + (longint'(1) << (FB - 1))) >>> FB;
        if (r > 8191)  r = 8191;
        if (r < -8192) r = -8192;
        e.score = int'(r) & 'h3FFF;
`else
        r = 0;
        e.score = int'(r);
`endif
        e.acc_cyc = acyc;
        e.min_len = mlen;
        return e;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Consumer: random back-pressure, with an occasional forced 10-cycle stall.
    initial begin
        int hold_used = 0;
        int hcnt = 0;
        bus.sym_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (hcnt > 0) begin
                bus.sym_ready = 1'b0;
                hcnt--;
            end else if (hold_used != hold_set && bus.sym_valid) begin
                hold_used++;
                hcnt = 9;
                bus.sym_ready = 1'b0;
            end else begin
                bus.sym_ready = (int'($urandom_range(0, 3)) != 0);
            end
        end
    end

    // Monitor: compares every presented result against the scoreboard head.
    initial begin
        bit   prev_v = 1'b0;
        bit   in_rst = 1'b0;
        int   vlen = 0;
        int   rd = 0;
        int   rise = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (!in_rst) begin
                    chk("rst_h_ready",   int'(bus.h_ready),   1);
                    chk("rst_sym_valid", int'(bus.sym_valid), 0);
                    chk("rst_sym",       int'(bus.sym),       0);
                    chk("rst_score",     int'(bus.score),     0);
                end
                in_rst = 1'b1;
                prev_v = 1'b0;
                vlen   = 0;
            end else begin
                in_rst = 1'b0;
                if (bus.sym_valid) begin
                    vlen++;
                    if (!prev_v) rise = cyc;
                    if (rd >= expq.size()) begin
                        chk("unexpected_sym_valid", int'(bus.sym_valid), 0);
                    end else begin
                        e = expq[rd];
                        chk("sym",   int'(bus.sym),   e.sym);
                        chk("score", int'(bus.score), e.score);
                        if (vlen == 1) chk("latency", rise - e.acc_cyc, 2*NC + 1);
                        if (bus.sym_ready) begin
                            chk("valid_hold_len", int'(vlen >= e.min_len), 1);
                            rd++;
                            done_cnt++;
                            vlen = 0;
                        end
                    end
                end
                prev_v = bus.sym_valid;
            end
        end
    end

    task automatic wr(input int a, input int v);
        bus.w_addr = AW'(a);
        bus.w_data = DW'(v);
        bus.w_we   = 1'b1;
        @(posedge clk);
        #1;
        bus.w_we = 1'b0;
        if (a < NP) pm[a] = s14(v);
    endtask

    task automatic clear_all();
        for (int a = 0; a < NP; a++) wr(a, 0);
    endtask

    task automatic send_elem(input int v, input bit wr_same, input int wa, input int wd);
        int n = 0;
        bus.h_data  = DW'(v);
        bus.h_valid = 1'b1;
        if (wr_same) begin
            bus.w_we   = 1'b1;
            bus.w_addr = AW'(wa);
            bus.w_data = DW'(wd);
        end
        @(negedge clk);
        while (!bus.h_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.h_ready) begin
            $display("FAIL h_ready_timeout got=0 exp=1 (cycle %0d)", cyc);
            $fatal(1, "h_ready never asserted");
        end
        last_acc = cyc;
        @(posedge clk);
        #1;
        bus.h_valid = 1'b0;
        bus.w_we    = 1'b0;
        if (wr_same && wa < NP) pm[wa] = s14(wd);
    endtask

    task automatic send_frame(input bit wr_same, input bit mac_wr, input bit hold);
        int n = 0;
        for (int k = 0; k < NH; k++) begin
            send_elem(hv[k], wr_same && (k == 0), int'($urandom_range(0, NP - 1)), int'($urandom));
            if (k == 0 && mac_wr) begin
                // DUT is in MAC now; this write must be dropped.
                bus.w_addr = AW'(int'($urandom_range(0, NP - 1)));
                bus.w_data = DW'(int'($urandom));
                bus.w_we   = 1'b1;
                @(posedge clk);
                #1;
                bus.w_we = 1'b0;
            end
        end
        if (hold) hold_set++;
        expq.push_back(model(last_acc, hold ? 11 : 1));
        sent_cnt++;
        while (done_cnt != sent_cnt && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt != sent_cnt) begin
            $display("FAIL result_timeout got=%0d exp=%0d", done_cnt, sent_cnt);
            $fatal(1, "result never taken");
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.h_valid = 1'b0;
        bus.h_data  = '0;
        bus.w_we    = 1'b0;
        bus.w_addr  = '0;
        bus.w_data  = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;

        // bias-only win
        clear_all();
        wr(5*(NH+1)+NH, 'h0400);
        for (int k = 0; k < NH; k++) hv[k] = 'h0400;
        send_frame(1'b0, 1'b0, 1'b0);

        // single weight win
        clear_all();
        wr(9*(NH+1)+3, 'h0800);
        for (int k = 0; k < NH; k++) hv[k] = 0;
        hv[3] = 'h0600;
        send_frame(1'b0, 1'b0, 1'b0);

        // all-zero tie resolves to class 0
        clear_all();
        for (int k = 0; k < NH; k++) hv[k] = s14(int'($urandom));
        send_frame(1'b0, 1'b0, 1'b0);

        // negative biases, least negative wins
        for (int j = 0; j < NC; j++) wr(j*(NH+1)+NH, (j == 12) ? 'h3E00 : 'h3C00);
        send_frame(1'b0, 1'b0, 1'b0);

        // saturation, with a 10-cycle consumer stall
        clear_all();
        for (int k = 0; k < NH; k++) begin
            wr(2*(NH+1)+k, 'h1FFF);
            hv[k] = 'h1FFF;
        end
        send_frame(1'b0, 1'b0, 1'b1);

        // out-of-range write is dropped
        wr(NP + int'($urandom_range(0, (1 << AW) - NP - 1)), int'($urandom));

        // random parameters and frames
        for (int a = 0; a < NP; a++) wr(a, int'($urandom));
        for (int it = 0; it < 12; it++) begin
            for (int w = 0; w < 20; w++) wr(int'($urandom_range(0, NP - 1)), int'($urandom));
            for (int k = 0; k < NH; k++) hv[k] = s14(int'($urandom));
            send_frame(it[0], 1'b1, (it % 4) == 0);
        end

        // reset after 7 accepts discards the partial frame
        for (int k = 0; k < 7; k++) send_elem(int'($urandom), 1'b0, 0, 0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < NH; k++) hv[k] = s14(int'($urandom));
        send_frame(1'b1, 1'b1, 1'b0);

        repeat (5) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/lstm_dense_decider.md
# lstm_dense_decider

Output stage of the LSTM ZigBee demodulator. It consumes the NUM_HIDDEN hidden-state values that the cell/hidden stage produces for one symbol period, one value per transfer. It computes NUM_CLASSES dense-layer logits (weights × hidden + bias) with a single serialized multiply-accumulate, then selects the winning class by argmax and emits it as the demodulated 4-bit ZigBee symbol over a valid/ready handshake.

## Interface
Parameters:
- DATA_WIDTH, 14, width of hidden values, weights and biases; signed fixed point with 1 sign, 3 integer and 10 fraction bits
- FRAC_BITS, 10, fraction bits of DATA_WIDTH operands
- NUM_HIDDEN, 16, hidden values per frame
- NUM_CLASSES, 16, output classes
- ACC_WIDTH, 32, signed accumulator width

Ports:
- clk  in  1  clock; all logic is rising-edge
- rst  in  1  asynchronous, active-low reset
- h_valid  in  1  hidden value offered
- h_ready  out  1  block can accept a hidden value
- h_data  in  DATA_WIDTH  hidden value, signed
- w_we  in  1  parameter write strobe
- w_addr  in  $clog2(NUM_CLASSES*(NUM_HIDDEN+1))  parameter address j*(NUM_HIDDEN+1)+k; k=NUM_HIDDEN selects the bias of class j
- w_data  in  DATA_WIDTH  parameter value, signed
- sym_valid  out  1  symbol result available
- sym_ready  in  1  consumer takes the result
- sym  out  $clog2(NUM_CLASSES)  winning class index
- score  out  DATA_WIDTH  winning logit (see Configuration)

## Operation
- States: IDLE, MAC, ARGMAX, DONE.
- **IDLE**
  - h_ready=1.
  - On h_valid&&h_ready: latch h_data as element k (k = internal counter, 0..NUM_HIDDEN-1), clear the class counter j, and go to MAC.
- **MAC**
  - h_ready=0. Spends one cycle per class j=0..NUM_CLASSES-1.
  - Per cycle: acc[j] += sext(W[j][k]*h), a full 2*DATA_WIDTH-bit product.
  - When k=0, acc[j] is first loaded with sext(bias[j])<<FRAC_BITS instead of being accumulated onto its old value.
  - After j=NUM_CLASSES-1: if k=NUM_HIDDEN-1, go to ARGMAX; otherwise increment k and return to IDLE.
- **ARGMAX**
  - One class per cycle, j=0..NUM_CLASSES-1.
  - Keeps the best index and value. Replacement only on strictly greater, so ties resolve to the lowest index.
  - Then go to DONE.
- **DONE**
  - sym_valid=1; sym and score stable.
  - On sym_ready: reset k to 0 and return to IDLE.
- **Parameter writes**
  - Honoured only in IDLE with k=0, i.e. between frames.
  - Ignored otherwise, and ignored for addresses ≥ NUM_CLASSES*(NUM_HIDDEN+1).
  - Parameter storage is not cleared by reset.
- **Arithmetic**
  - Signed two's complement throughout.
  - Accumulation wraps at ACC_WIDTH. The defaults cannot overflow: 16 products of at most 2^26 each, plus the bias.
- **Reset, asynchronous, any state:** state=IDLE, k=0, j=0, accumulators=0, h_ready=1, sym_valid=0, sym=0, score=0. A partially received frame is discarded.

## Timing
- h_data is accepted on the cycle of the handshake. MAC then occupies the next NUM_CLASSES cycles, and h_ready returns to 1 in the following cycle.
- Back-to-back element throughput: one accept every NUM_CLASSES+1 cycles.
- Last accept at cycle T:
  - MAC: T+1..T+NC
  - ARGMAX: T+NC+1..T+2NC
  - sym_valid rises at T+2NC+1 (T+33 with defaults)
- sym_valid remains asserted, with sym and score unchanged, until sym_ready is sampled high. With sym_ready tied high, sym_valid lasts 1 cycle.
- h_ready is 0 in DONE: the next frame cannot start before the result is taken.
- w_we on the same cycle as an IDLE accept with k=0: the write completes, and the MAC pass uses the new value.

## Configuration
- DENSE_SCORE_OUT_EN defined:
  - score = winning accumulator rounded half-up at bit FRAC_BITS-1, shifted right by FRAC_BITS.
  - The result saturates to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- Undefined: score is constant 0 and the rounding/saturation logic is not built.

## Test plan
- **Reset values:** during reset, h_ready=1, sym_valid=0, sym=0, score=0.
- **Bias-only win:** all weights 0, bias[5]=14'h0400, other biases 0, 16 hidden values of 14'h0400 → sym=5, score=14'h0400 (with macro).
- **Weight win:** W[9][3]=14'h0800 (2.0), h[3]=14'h0600 (1.5), all other parameters 0 → sym=9, score=14'h0C00. sym_valid rises exactly 33 cycles after the 16th accept.
- **Tie/negative:** all parameters 0 → sym=0. With all biases 14'h3C00 (-1.0), except bias[12]=14'h3E00 (-0.5) → sym=12, score=14'h3E00.
- **Saturation (macro on):** W[2][k]=14'h1FFF and h=14'h1FFF for all k → sym=2, score=14'h1FFF. Macro off: score=0.
- **Reset mid-frame and write lockout:**
  - Assert rst after 7 accepts, then send a fresh 16-value frame → the result reflects only the fresh frame.
  - A w_we issued during MAC is ignored.
  - sym_ready held low for 10 cycles → sym_valid held, sym stable.
